// File: rtl/clahe_hist_pkg.sv
// Shared types and helpers for the CLAHE tile-histogram RAM bank logic.
package clahe_hist_pkg;

    localparam int BIN_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    // Widest bank bus any instance may use; callers truncate to their own width.
    localparam int MAX_BANKS  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    function automatic logic [MAX_BANKS-1:0] group_mask(input int grp, input int gsize,
                                                        input int nbanks);
        logic [MAX_BANKS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BANKS; i++) begin
            m[i] = (i < nbanks) && ((i / gsize) == grp);
        end
        return m;
    endfunction

endpackage

// File: rtl/histogram_bank_clear_if.sv
// Request and RAM-write bundle between the equalisation controller and the clear engine.
interface histogram_bank_clear_if
    import clahe_hist_pkg::*;
#(
    parameter int NUM_BANKS  = 32,
    parameter int GROUP_SIZE = 16,
    parameter int BIN_W      = BIN_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) ();

    localparam int NUM_GROUPS = NUM_BANKS / GROUP_SIZE;
    localparam int GSEL_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    logic                 start;
    logic [GSEL_W-1:0]    group_sel;
    logic [DATA_W-1:0]    fill_value;
    logic                 abort;
    logic [NUM_BANKS-1:0] wr_en;
    logic [BIN_W-1:0]     wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 busy;
    logic                 done;
    logic                 req_overflow;

    modport master (
        output start, group_sel, fill_value, abort,
        input  wr_en, wr_addr, wr_data, busy, done, req_overflow
    );

    modport slave (
        input  start, group_sel, fill_value, abort,
        output wr_en, wr_addr, wr_data, busy, done, req_overflow
    );

endinterface

// File: rtl/clear_req_queue.sv
// Single-entry pending clear request buffer with a sticky overflow flag.
module clear_req_queue #(
    parameter int GSEL_W = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              reject_i,
    input  logic [GSEL_W-1:0] grp_i,
    input  logic [DATA_W-1:0] fill_i,
    output logic              valid_o,
    output logic [GSEL_W-1:0] grp_o,
    output logic [DATA_W-1:0] fill_o,
    output logic              overflow_o
);

    logic              valid_q;
    logic              ovf_q;
    logic [GSEL_W-1:0] grp_q;
    logic [DATA_W-1:0] fill_q;
    logic              accept_d;

    // A slot being popped this cycle can take the new request in the same cycle.
    assign accept_d = !flush_i && push_i && (!valid_q || pop_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (push_i) begin
                if (accept_d) valid_q <= 1'b1;
                else          ovf_q   <= 1'b1;
            end else if (pop_i) begin
                valid_q <= 1'b0;
            end
            if (reject_i) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_d) begin
            grp_q  <= grp_i;
            fill_q <= fill_i;
        end
    end

    assign valid_o    = valid_q;
    assign grp_o      = grp_q;
    assign fill_o     = fill_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/histogram_bank_clear.sv
// Sweeps every bin of one bank group, writing a fill value to all banks of the group in parallel.
module histogram_bank_clear
    import clahe_hist_pkg::*;
#(
    parameter int NUM_BANKS  = 32,
    parameter int GROUP_SIZE = 16,
    parameter int BIN_W      = BIN_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input logic                   clk,
    input logic                   rst,
    histogram_bank_clear_if.slave bus
);

    localparam int              NUM_GROUPS   = NUM_BANKS / GROUP_SIZE;
    localparam int              GSEL_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GSEL_W:0] NUM_GROUPS_W = (GSEL_W + 1)'(NUM_GROUPS);
    localparam logic [BIN_W-1:0] CNT_LAST    = '1;

    clr_state_e           state_q;
    logic [BIN_W-1:0]     cnt_q;
    logic [NUM_BANKS-1:0] wr_en_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 start_ok;
    logic                 grp_ok;
    logic                 launch_d;
    logic                 push_d;
    logic                 pop_d;
    logic                 reject_d;
    logic [GSEL_W-1:0]    launch_grp_d;
    logic [DATA_W-1:0]    launch_fill_d;
    logic [NUM_BANKS-1:0] launch_mask_d;

    logic                 q_valid;
    logic [GSEL_W-1:0]    q_grp;
    logic [DATA_W-1:0]    q_fill;
    logic                 q_ovf;

    assign start_ok = bus.start && !bus.abort;
    assign grp_ok   = {1'b0, bus.group_sel} < NUM_GROUPS_W;

    always_comb begin
        launch_d      = 1'b0;
        push_d        = 1'b0;
        pop_d         = 1'b0;
        reject_d      = start_ok && !grp_ok;
        launch_grp_d  = bus.group_sel;
        launch_fill_d = bus.fill_value;
        case (state_q)
            IDLE:  launch_d = start_ok && grp_ok;
            SWEEP: push_d   = start_ok && grp_ok;
            DONE: begin
                // A queued request wins the relaunch; a fresh start then refills the slot.
                if (q_valid) begin
                    launch_d      = 1'b1;
                    pop_d         = 1'b1;
                    push_d        = start_ok && grp_ok;
                    launch_grp_d  = q_grp;
                    launch_fill_d = q_fill;
                end else begin
                    launch_d = start_ok && grp_ok;
                end
            end
            default: launch_d = 1'b0;
        endcase
        launch_mask_d = NUM_BANKS'(group_mask(int'({{(32 - GSEL_W){1'b0}}, launch_grp_d}),
                                              GROUP_SIZE, NUM_BANKS));
    end

    clear_req_queue #(
        .GSEL_W (GSEL_W),
        .DATA_W (DATA_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.abort),
        .push_i     (push_d),
        .pop_i      (pop_d),
        .reject_i   (reject_d),
        .grp_i      (bus.group_sel),
        .fill_i     (bus.fill_value),
        .valid_o    (q_valid),
        .grp_o      (q_grp),
        .fill_o     (q_fill),
        .overflow_o (q_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.abort) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (launch_d) begin
                        state_q   <= SWEEP;
                        cnt_q     <= '0;
                        wr_en_q   <= launch_mask_d;
                        wr_data_q <= launch_fill_d;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SWEEP: begin
                    // cnt_q is the address on the bus this cycle, so the last bin ends the sweep.
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        cnt_q     <= '0;
                        wr_en_q   <= '0;
                        wr_data_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = cnt_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.req_overflow = q_ovf;

endmodule

// File: tb/tb_histogram_bank_clear.sv
// Bench for histogram_bank_clear: transaction-level model on the default instance, directed checks on small ones.
module tb_histogram_bank_clear;

    localparam int NB = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    histogram_bank_clear_if #(.NUM_BANKS(32), .GROUP_SIZE(16), .BIN_W(8), .DATA_W(16)) mb ();
    histogram_bank_clear_if #(.NUM_BANKS(8),  .GROUP_SIZE(2),  .BIN_W(4), .DATA_W(16)) sb ();
    histogram_bank_clear_if #(.NUM_BANKS(6),  .GROUP_SIZE(2),  .BIN_W(2), .DATA_W(16)) xb ();

    histogram_bank_clear #(.NUM_BANKS(32), .GROUP_SIZE(16), .BIN_W(8), .DATA_W(16)) u_main (
        .clk (clk), .rst (rst), .bus (mb.slave));
    histogram_bank_clear #(.NUM_BANKS(8), .GROUP_SIZE(2), .BIN_W(4), .DATA_W(16)) u_small (
        .clk (clk), .rst (rst), .bus (sb.slave));
    histogram_bank_clear #(.NUM_BANKS(6), .GROUP_SIZE(2), .BIN_W(2), .DATA_W(16)) u_odd (
        .clk (clk), .rst (rst), .bus (xb.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model of the default instance: a live sweep started at cycle base shows bin (cyc-base),
    // the done pulse at cyc-base == NB, plus a one-slot pending request and a sticky overflow.
    int cyc = 0;
    int base = 0;
    bit live = 1'b0;
    bit pv = 1'b0;
    int pg = 0;
    int pf = 0;
    int m_grp = 0;
    int m_fill = 0;
    bit m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int kp;
        if (rst) begin
            live  = 1'b0;
            pv    = 1'b0;
            m_ovf = 1'b0;
        end else begin
            cyc++;
            kp = cyc - 1 - base;
            if (mb.abort) begin
                live = 1'b0;
                pv   = 1'b0;
            end else if (live && kp < NB) begin
                if (mb.start) begin
                    if (pv) m_ovf = 1'b1;
                    else begin pv = 1'b1; pg = int'(mb.group_sel); pf = int'(mb.fill_value); end
                end
            end else if (live && kp == NB && pv) begin
                live = 1'b1; base = cyc; m_grp = pg; m_fill = pf; pv = 1'b0;
                if (mb.start) begin pv = 1'b1; pg = int'(mb.group_sel); pf = int'(mb.fill_value); end
            end else if (mb.start) begin
                live = 1'b1; base = cyc; m_grp = int'(mb.group_sel); m_fill = int'(mb.fill_value);
            end else begin
                live = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int k;
        bit wr;
        bit dn;
        k  = cyc - base;
        wr = live && (k >= 0) && (k < NB);
        dn = live && (k == NB);
        chk("m_wr_en",   64'(mb.wr_en),   wr ? 64'(32'h0000_FFFF << (16 * m_grp)) : 64'd0);
        chk("m_wr_addr", 64'(mb.wr_addr), wr ? 64'(k) : 64'd0);
        chk("m_wr_data", 64'(mb.wr_data), wr ? 64'(m_fill) : 64'd0);
        chk("m_busy",    64'(mb.busy),    64'(wr));
        chk("m_done",    64'(mb.done),    64'(dn));
        chk("m_ovf",     64'(mb.req_overflow), 64'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pstart(input logic g, input logic [15:0] f);
        mb.start      = 1'b1;
        mb.group_sel  = g;
        mb.fill_value = f;
        tick();
        mb.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (mb.done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(mb.done), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int dcnt;
        mb.start = 1'b0; mb.group_sel = '0; mb.fill_value = '0; mb.abort = 1'b0;
        sb.start = 1'b0; sb.group_sel = '0; sb.fill_value = '0; sb.abort = 1'b0;
        xb.start = 1'b0; xb.group_sel = '0; xb.fill_value = '0; xb.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(mb.wr_en), 64'd0);
        chk("rst_busy",  64'(mb.busy),  64'd0);
        chk("rst_done",  64'(mb.done),  64'd0);
        chk("rst_ovf",   64'(mb.req_overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Plain clear of group 0
        pstart(1'b0, 16'h0000);
        chk("t1_en0",   64'(mb.wr_en),   64'h0000_FFFF);
        chk("t1_addr0", 64'(mb.wr_addr), 64'd0);
        repeat (255) tick();
        chk("t1_addr255", 64'(mb.wr_addr), 64'd255);
        chk("t1_busy255", 64'(mb.busy),    64'd1);
        tick();
        chk("t1_done",      64'(mb.done),  64'd1);
        chk("t1_done_busy", 64'(mb.busy),  64'd0);
        chk("t1_done_en",   64'(mb.wr_en), 64'd0);
        tick();
        chk("t1_done_once", 64'(mb.done),  64'd0);

        // Fill value 4 into group 1
        pstart(1'b1, 16'h0004);
        chk("t2_en",   64'(mb.wr_en),   64'hFFFF_0000);
        chk("t2_data", 64'(mb.wr_data), 64'd4);
        wait_done();
        tick();

        // Second request queued at bin 100
        pstart(1'b1, 16'h0007);
        repeat (100) tick();
        chk("t3_addr100", 64'(mb.wr_addr), 64'd100);
        pstart(1'b0, 16'h0009);
        wait_done();
        chk("t3_ovf", 64'(mb.req_overflow), 64'd0);
        tick();
        chk("t3_en",   64'(mb.wr_en),   64'h0000_FFFF);
        chk("t3_addr", 64'(mb.wr_addr), 64'd0);
        chk("t3_data", 64'(mb.wr_data), 64'd9);
        wait_done();
        tick();

        // Three starts in one sweep: queue one, drop one
        pstart(1'b0, 16'h0001);
        repeat (10) tick();
        pstart(1'b1, 16'h0002);
        repeat (10) tick();
        pstart(1'b0, 16'h0003);
        chk("t4_ovf_set", 64'(mb.req_overflow), 64'd1);
        wait_done();
        tick();
        chk("t4_q_en",   64'(mb.wr_en),   64'hFFFF_0000);
        chk("t4_q_data", 64'(mb.wr_data), 64'd2);
        wait_done();
        tick();
        chk("t4_ovf_sticky", 64'(mb.req_overflow), 64'd1);

        // Abort at bin 37 with a request queued
        pstart(1'b1, 16'h0005);
        repeat (10) tick();
        pstart(1'b0, 16'h0006);
        repeat (26) tick();
        chk("t5_addr37", 64'(mb.wr_addr), 64'd37);
        mb.abort = 1'b1;
        tick();
        mb.abort = 1'b0;
        chk("t5_en_off",   64'(mb.wr_en), 64'd0);
        chk("t5_busy_off", 64'(mb.busy),  64'd0);
        dcnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (mb.done === 1'b1) dcnt++;
        end
        chk("t5_no_done", 64'(dcnt), 64'd0);
        mb.start = 1'b1; mb.abort = 1'b1; mb.group_sel = 1'b1;
        tick();
        mb.start = 1'b0; mb.abort = 1'b0;
        chk("t5_start_abort", 64'(mb.busy), 64'd0);
        pstart(1'b0, 16'h0008);
        chk("t5_new_en",   64'(mb.wr_en),   64'h0000_FFFF);
        chk("t5_new_addr", 64'(mb.wr_addr), 64'd0);
        wait_done();
        tick();

        // Asynchronous reset at bin 200
        pstart(1'b1, 16'h0003);
        repeat (200) tick();
        chk("t6_addr200", 64'(mb.wr_addr), 64'd200);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_en",   64'(mb.wr_en),   64'd0);
        chk("t6_rst_addr", 64'(mb.wr_addr), 64'd0);
        chk("t6_rst_busy", 64'(mb.busy),    64'd0);
        chk("t6_rst_ovf",  64'(mb.req_overflow), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();

        // Small instance: group 3 of 8 banks, 16 bins
        sb.group_sel = 2'd3; sb.fill_value = 16'h00AB; sb.start = 1'b1;
        tick();
        sb.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("s_en",   64'(sb.wr_en),   64'hC0);
            chk("s_addr", 64'(sb.wr_addr), 64'(i));
            chk("s_data", 64'(sb.wr_data), 64'hAB);
            tick();
        end
        chk("s_done", 64'(sb.done), 64'd1);
        chk("s_busy", 64'(sb.busy), 64'd0);
        tick();

        // Three-group instance: out-of-range group rejected, valid group sweeps 4 bins
        xb.group_sel = 2'd3; xb.start = 1'b1;
        tick();
        xb.start = 1'b0;
        chk("x_rej_busy", 64'(xb.busy),  64'd0);
        chk("x_rej_en",   64'(xb.wr_en), 64'd0);
        chk("x_rej_ovf",  64'(xb.req_overflow), 64'd1);
        xb.group_sel = 2'd2; xb.fill_value = 16'h0011; xb.start = 1'b1;
        tick();
        xb.start = 1'b0;
        chk("x_en",    64'(xb.wr_en),   64'h30);
        chk("x_addr0", 64'(xb.wr_addr), 64'd0);
        repeat (3) tick();
        chk("x_addr3", 64'(xb.wr_addr), 64'd3);
        tick();
        chk("x_done",  64'(xb.done),    64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
